tpx3_rx_merger: RTL and testbench
=================================

TPX3_RX_MERGER -- requirements
Module: tpx3_rx_merger

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of receiver FIFO sources, legal range 1..15.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of each per-channel word counter.
REQ-003 SHALL have port BUS_CLK  in  1  single clock for all logic.
REQ-004 SHALL have port BUS_RST  in  1  asynchronous active-low reset.
REQ-005 SHALL have port CH_FIFO_EMPTY  in  CHANNELS  per-channel source empty flag, first-word-fall-through.
REQ-006 SHALL have port CH_FIFO_DATA  in  32*CHANNELS  channel i data at bits [32i+31:32i].
REQ-007 SHALL have port CH_FIFO_READ  out  CHANNELS  one-cycle pop strobe per channel.
REQ-008 SHALL have port CH_ENABLE  in  CHANNELS  per-channel arbitration enable.
REQ-009 SHALL have port CNT_EN  in  1  enables the internal counter test source.
REQ-010 SHALL have port CNT_CLEAR  in  1  synchronous clear of all word counters.
REQ-011 SHALL have port OUT_READ  in  1  downstream accepts OUT_DATA this cycle.
REQ-012 SHALL have port OUT_VALID  out  1  OUT_DATA holds an unconsumed word.
REQ-013 SHALL have port OUT_DATA  out  32  merged output word.
REQ-014 SHALL have port WORD_CNT  out  CNT_WIDTH*CHANNELS  per-channel popped-word count, channel i at [CNT_WIDTH*i+CNT_WIDTH-1:CNT_WIDTH*i].

Function
REQ-015 SHALL treat CHANNELS+1 sources: channel i requests when CH_FIFO_EMPTY[i]=0 and CH_ENABLE[i]=1; source CHANNELS (counter) requests when CNT_EN=1.
REQ-016 SHALL arbitrate only in cycles where the output slot is free: OUT_VALID=0, or OUT_VALID=1 and OUT_READ=1.
REQ-017 SHALL grant round-robin: search starts at last-granted index +1, wraps modulo CHANNELS+1, first requester wins.
REQ-018 SHALL, on granting channel i, assert CH_FIFO_READ[i] for exactly that cycle and load CH_FIFO_DATA[i] into OUT_DATA on the same edge; OUT_VALID=1 next cycle (latency 1).
REQ-019 SHALL sustain one word per cycle while OUT_READ stays 1 and requests persist.
REQ-020 SHALL, when the slot is free and no source requests, clear OUT_VALID on the next edge; OUT_DATA holds its last value.
REQ-021 SHALL keep OUT_DATA and OUT_VALID stable while OUT_VALID=1 and OUT_READ=0; no CH_FIFO_READ asserted then.
REQ-022 SHALL ignore OUT_READ while OUT_VALID=0.
REQ-023 SHALL never assert CH_FIFO_READ for a channel with CH_FIFO_EMPTY=1 or CH_ENABLE=0 in that cycle; deasserting enable takes effect in the same cycle.
REQ-024 SHALL keep a 32-bit test counter, incremented by 1 on each counter-source grant, wrapping from 0xFFFFFFFF to 0; granted word is the pre-increment value.
REQ-025 SHALL increment WORD_CNT[i] on each CH_FIFO_READ[i], saturating at all-ones.
REQ-026 SHALL give CNT_CLEAR priority over a simultaneous increment, leaving that counter at 0.

Reset
REQ-027 SHALL, on BUS_RST=0 asynchronously: OUT_VALID=0, OUT_DATA=0, CH_FIFO_READ=0, WORD_CNT=0, test counter=0, last-granted pointer=CHANNELS (channel 0 wins first).
REQ-028 SHALL discard any held output word on reset mid-operation; no pop occurs until BUS_RST has returned high for one BUS_CLK edge.

Configuration
REQ-029 SHALL, with macro TPX3_MERGER_CHANNEL_TAG_EN defined, output channel i words as {i[3:0], data[27:0]} and counter words as {4'hF, counter[27:0]}.
REQ-030 SHALL, without TPX3_MERGER_CHANNEL_TAG_EN, pass channel data and the full 32-bit counter unmodified.

Verification
REQ-031 SHALL cover: CHANNELS=4, all channels hold 3 words, OUT_READ=1 constant -> pop order 0,1,2,3,0,1,2,3,0,1,2,3, 12 consecutive valid cycles, WORD_CNT each =3.
REQ-032 SHALL cover: OUT_VALID=1, OUT_READ=0 for 5 cycles while channel 2 non-empty -> OUT_DATA unchanged, CH_FIFO_READ stays 0.
REQ-033 SHALL cover: CH_ENABLE=4'b1011, all non-empty -> channel 2 never popped, order 0,1,3,0,...
REQ-034 SHALL cover: CNT_EN=1 only, tag macro defined, 3 reads -> OUT_DATA 0xF0000000, 0xF0000001, 0xF0000002; without macro 0x00000000, 0x00000001, 0x00000002.
REQ-035 SHALL cover: CNT_WIDTH=4, 17 pops on channel 0 with CNT_CLEAR asserted together with pop 17 -> WORD_CNT[0] reaches 15, stays 15, reads 0 after the clear.
REQ-036 SHALL cover: BUS_RST low for 1 cycle while OUT_VALID=1 -> OUT_VALID=0 immediately, next grant goes to channel 0.

Source files
------------

// File: rtl/tpx3_rx_merger.sv
// Round-robin merger of CHANNELS FWFT receiver FIFOs plus a counter test source into one 32-bit stream.
// Optional macro TPX3_MERGER_CHANNEL_TAG_EN replaces the top nibble of each word with its source id.
module tpx3_rx_merger #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                            BUS_CLK,
   input  logic                            BUS_RST,
   input  logic [CHANNELS-1:0]             CH_FIFO_EMPTY,
   input  logic [32*CHANNELS-1:0]          CH_FIFO_DATA,
   output logic [CHANNELS-1:0]             CH_FIFO_READ,
   input  logic [CHANNELS-1:0]             CH_ENABLE,
   input  logic                            CNT_EN,
   input  logic                            CNT_CLEAR,
   input  logic                            OUT_READ,
   output logic                            OUT_VALID,
   output logic [31:0]                     OUT_DATA,
   output logic [CNT_WIDTH*CHANNELS-1:0]   WORD_CNT
);

   localparam int             NSRC    = CHANNELS + 1;
   localparam int             PW      = $clog2(NSRC);
   localparam logic [PW-1:0]  PTR_CNT = PW'(CHANNELS);
   localparam logic [PW:0]    NSRC_W  = (PW+1)'(NSRC);

   logic                  r_run;
   logic                  r_valid;
   logic [31:0]           r_data;
   logic [31:0]           r_tcnt;
   logic [PW-1:0]         r_last;
   logic [CNT_WIDTH-1:0]  r_wcnt [CHANNELS];

   logic [NSRC-1:0]       w_req;
   logic                  w_free;
   logic                  w_gnt_any;
   logic [PW-1:0]         w_gnt_idx;
   logic [31:0]           w_word;

   assign w_req  = {CNT_EN, ~CH_FIFO_EMPTY & CH_ENABLE};
   // r_run holds off pops until one clock edge has passed after reset release
   assign w_free = r_run & (~r_valid | OUT_READ);

   always_comb begin
      logic [PW:0] w_sum;
      w_gnt_any = 1'b0;
      w_gnt_idx = r_last;
      w_sum     = '0;
      // scan from farthest to nearest so the nearest requester after r_last wins
      for (int k = NSRC; k >= 1; k--) begin
         w_sum = {1'b0, r_last} + (PW+1)'(k);
         if (w_sum >= NSRC_W) w_sum = w_sum - NSRC_W;
         if (w_req[w_sum[PW-1:0]]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_sum[PW-1:0];
         end
      end
   end

   always_comb begin
`ifdef TPX3_MERGER_CHANNEL_TAG_EN
      w_word = {4'hF, r_tcnt[27:0]};
`else
      w_word = r_tcnt;
`endif
      CH_FIFO_READ = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_gnt_idx == PW'(c)) begin
`ifdef TPX3_MERGER_CHANNEL_TAG_EN
            w_word = {4'(c), CH_FIFO_DATA[32*c +: 28]};
`else
            w_word = CH_FIFO_DATA[32*c +: 32];
`endif
            CH_FIFO_READ[c] = w_free & w_gnt_any;
         end
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
      if (!BUS_RST) begin
         r_run   <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tcnt  <= '0;
         r_last  <= PTR_CNT;
      end else begin
         r_run <= 1'b1;
         if (w_free) begin
            if (w_gnt_any) begin
               r_valid <= 1'b1;
               r_data  <= w_word;
               r_last  <= w_gnt_idx;
               if (w_gnt_idx == PTR_CNT) r_tcnt <= r_tcnt + 32'd1;
            end else begin
               r_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
      if (!BUS_RST) begin
         for (int c = 0; c < CHANNELS; c++) r_wcnt[c] <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (CNT_CLEAR)
               r_wcnt[c] <= '0;
            else if (CH_FIFO_READ[c] && (r_wcnt[c] != {CNT_WIDTH{1'b1}}))
               r_wcnt[c] <= r_wcnt[c] + CNT_WIDTH'(1);
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_wcnt
      assign WORD_CNT[CNT_WIDTH*g +: CNT_WIDTH] = r_wcnt[g];
   end

   assign OUT_VALID = r_valid;
   assign OUT_DATA  = r_data;

endmodule

// File: tb/tb_tpx3_rx_merger.sv
// Directed bench for tpx3_rx_merger (CHANNELS=4, CNT_WIDTH=4) with behavioural FWFT source FIFOs.
// Expected words follow TPX3_MERGER_CHANNEL_TAG_EN when it is defined for the build.
module tb_tpx3_rx_merger;

   logic          BUS_CLK = 1'b0;
   logic          BUS_RST = 1'b0;
   logic [3:0]    CH_FIFO_EMPTY;
   logic [127:0]  CH_FIFO_DATA;
   logic [3:0]    CH_FIFO_READ;
   logic [3:0]    CH_ENABLE = 4'hF;
   logic          CNT_EN = 1'b0;
   logic          CNT_CLEAR = 1'b0;
   logic          OUT_READ = 1'b1;
   logic          OUT_VALID;
   logic [31:0]   OUT_DATA;
   logic [15:0]   WORD_CNT;

   tpx3_rx_merger #(.CHANNELS(4), .CNT_WIDTH(4)) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
      .CH_FIFO_EMPTY(CH_FIFO_EMPTY), .CH_FIFO_DATA(CH_FIFO_DATA),
      .CH_FIFO_READ(CH_FIFO_READ), .CH_ENABLE(CH_ENABLE),
      .CNT_EN(CNT_EN), .CNT_CLEAR(CNT_CLEAR), .OUT_READ(OUT_READ),
      .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .WORD_CNT(WORD_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   logic [31:0] mem [4][32];
   logic [4:0]  rd_ptr [4] = '{default: 5'd0};
   logic [4:0]  wr_ptr [4] = '{default: 5'd0};
   int          bad_pops = 0;

   for (genvar g = 0; g < 4; g++) begin : g_fifo
      assign CH_FIFO_EMPTY[g]      = (rd_ptr[g] == wr_ptr[g]);
      assign CH_FIFO_DATA[32*g +: 32] = mem[g][rd_ptr[g]];
   end

   always @(posedge BUS_CLK) begin
      for (int c = 0; c < 4; c++) begin
         if (CH_FIFO_READ[c]) begin
            if (CH_FIFO_EMPTY[c] || !CH_ENABLE[c]) bad_pops <= bad_pops + 1;
            rd_ptr[c] <= rd_ptr[c] + 5'd1;
         end
      end
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] got [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] wd(input int c, input int k);
      return 32'hA000_0000 | (32'(c) << 20) | 32'(k);
   endfunction

   function automatic logic [31:0] ex_ch(input int c, input int k);
      logic [31:0] w;
      w = wd(c, k);
`ifdef TPX3_MERGER_CHANNEL_TAG_EN
      return {4'(c), w[27:0]};
`else
      return w;
`endif
   endfunction

   function automatic logic [31:0] ex_cnt(input int n);
`ifdef TPX3_MERGER_CHANNEL_TAG_EN
      return {4'hF, 28'(n)};
`else
      return 32'(n);
`endif
   endfunction

   task automatic push(input int c, input int k);
      mem[c][wr_ptr[c]] = wd(c, k);
      wr_ptr[c] = wr_ptr[c] + 5'd1;
   endtask

   task automatic rst_on();
      @(negedge BUS_CLK);
      BUS_RST = 1'b0;
   endtask

   task automatic rst_off();
      @(negedge BUS_CLK);
      BUS_RST = 1'b1;
   endtask

   task automatic collect(input int n, input int maxcyc, output int got_n,
                          output int first_c, output int last_c);
      got_n = 0; first_c = -1; last_c = -1;
      for (int cyc = 0; cyc < maxcyc && got_n < n; cyc++) begin
         @(negedge BUS_CLK);
         if (OUT_VALID && OUT_READ) begin
            got[got_n] = OUT_DATA;
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
            got_n++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gn, fc, lc, pd, done;
      int s15, s16;
      logic [4:0] base;
      int exp_ch3 [6];

      // reset values with all FIFOs holding data
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++) push(c, k);
      repeat (2) @(negedge BUS_CLK);
      chk("rst_valid", 32'(OUT_VALID), 0);
      chk("rst_data", OUT_DATA, 0);
      chk("rst_read", 32'(CH_FIFO_READ), 0);
      chk("rst_wcnt", 32'(WORD_CNT), 0);

      // full round-robin drain, one word per cycle
      BUS_RST = 1'b1;
      collect(12, 40, gn, fc, lc);
      chk("rr_count", gn, 12);
      chk("rr_contig", lc - fc + 1, 12);
      for (int i = 0; i < 12; i++) chk($sformatf("rr_word%0d", i), got[i], ex_ch(i % 4, i / 4));
      for (int c = 0; c < 4; c++) chk($sformatf("rr_wcnt%0d", c), 32'(WORD_CNT[4*c +: 4]), 3);
      @(negedge BUS_CLK);
      chk("idle_valid", 32'(OUT_VALID), 0);
      chk("idle_data_hold", OUT_DATA, ex_ch(3, 2));

      // backpressure: held word stays, no pops
      OUT_READ = 1'b0;
      push(2, 3); push(2, 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge BUS_CLK);
         chk("bp_valid", 32'(OUT_VALID), 1);
         chk("bp_data", OUT_DATA, ex_ch(2, 3));
         chk("bp_read", 32'(CH_FIFO_READ), 0);
      end
      OUT_READ = 1'b1;
      @(negedge BUS_CLK);
      chk("bp_next", OUT_DATA, ex_ch(2, 4));
      @(negedge BUS_CLK);
      chk("bp_drained", 32'(OUT_VALID), 0);

      // channel 2 disabled
      rst_on();
      CH_ENABLE = 4'b1011;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) push(c, 8'h30 + k);
      rst_off();
      collect(6, 30, gn, fc, lc);
      chk("en_count", gn, 6);
      exp_ch3 = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 6; i++) chk($sformatf("en_word%0d", i), got[i], ex_ch(exp_ch3[i], 8'h30 + i / 3));
      @(negedge BUS_CLK);
      chk("en_ch2_left", 32'(wr_ptr[2] - rd_ptr[2]), 2);
      chk("en_ch2_wcnt", 32'(WORD_CNT[11:8]), 0);
      CH_ENABLE = 4'hF;
      collect(2, 20, gn, fc, lc);
      chk("en_ch2_count", gn, 2);
      chk("en_ch2_w0", got[0], ex_ch(2, 8'h30));
      chk("en_ch2_w1", got[1], ex_ch(2, 8'h31));

      // counter test source only
      rst_on();
      rst_off();
      CNT_EN = 1'b1;
      collect(3, 20, gn, fc, lc);
      CNT_EN = 1'b0;
      chk("cnt_count", gn, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("cnt_word%0d", i), got[i], ex_cnt(i));
      @(negedge BUS_CLK);
      chk("cnt_stop", 32'(OUT_VALID), 0);

      // word counter saturation and clear colliding with a pop
      rst_on();
      for (int k = 0; k < 17; k++) push(0, 8'h50 + k);
      base = rd_ptr[0];
      rst_off();
      done = 0; s15 = 0; s16 = 0;
      for (int cyc = 0; cyc < 60 && done == 0; cyc++) begin
         @(negedge BUS_CLK);
         pd = int'(5'(rd_ptr[0] - base));
         if (pd == 15 && s15 == 0) begin chk("wcnt_15", 32'(WORD_CNT[3:0]), 15); s15 = 1; end
         if (pd == 16 && s16 == 0) begin chk("wcnt_sat", 32'(WORD_CNT[3:0]), 15); s16 = 1; end
         if (pd == 16 && CH_FIFO_READ[0]) CNT_CLEAR = 1'b1;
         if (pd == 17) begin
            CNT_CLEAR = 1'b0;
            chk("wcnt_clr", 32'(WORD_CNT[3:0]), 0);
            done = 1;
         end
      end
      chk("wcnt_seq_done", done, 1);
      chk("wcnt_seen", s15 + s16, 2);
      repeat (3) @(negedge BUS_CLK);

      // reset pulse while a word is held
      rst_on();
      OUT_READ = 1'b0;
      push(1, 8'h60); push(1, 8'h61);
      rst_off();
      repeat (3) @(negedge BUS_CLK);
      chk("mid_valid", 32'(OUT_VALID), 1);
      chk("mid_data", OUT_DATA, ex_ch(1, 8'h60));
      push(0, 8'h62);
      BUS_RST = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(OUT_VALID), 0);
      chk("mid_rst_data", OUT_DATA, 0);
      chk("mid_rst_read", 32'(CH_FIFO_READ), 0);
      @(negedge BUS_CLK);
      BUS_RST = 1'b1;
      OUT_READ = 1'b1;
      #1;
      chk("mid_rel_read", 32'(CH_FIFO_READ), 0);
      collect(2, 20, gn, fc, lc);
      chk("mid_count", gn, 2);
      chk("mid_first_ch0", got[0], ex_ch(0, 8'h62));
      chk("mid_then_ch1", got[1], ex_ch(1, 8'h61));

      @(negedge BUS_CLK);
      chk("bad_pops", bad_pops, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
